// File: rtl/unpatchifier.sv
// Unpatchifier: reorders a patch-major pixel stream into image raster order.
// A band buffer of PATCH_SIZE rows x IMG_WIDTH columns is filled from one patch
// row, then drained row by row; the sequence repeats for every band of the frame.
// Optional build macro UNPATCHIFIER_MARKERS_EN adds out_eol / out_last markers.
module unpatchifier #(
    parameter int unsigned CHANNEL_SIZE    = 8,
    parameter int unsigned NUM_CHANNELS    = 3,
    parameter int unsigned PIXEL_WIDTH     = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int unsigned IMG_WIDTH       = 64,
    parameter int unsigned IMG_HEIGHT      = 64,
    parameter int unsigned PATCH_SIZE      = 16,
    parameter int unsigned PATCH_SIZE_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [PIXEL_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [PIXEL_WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [1:0]             state,
    output logic                   frame_done
`ifdef UNPATCHIFIER_MARKERS_EN
    ,
    output logic                   out_eol,
    output logic                   out_last
`endif
);

    localparam int unsigned BAND_PIX  = PATCH_SIZE * IMG_WIDTH;
    localparam int unsigned AW        = (BAND_PIX > 1) ? $clog2(BAND_PIX) : 1;
    localparam int unsigned NUM_BANDS = IMG_HEIGHT / PATCH_SIZE;
    localparam int unsigned BW        = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int unsigned POS_MASK  = PATCH_SIZE * PATCH_SIZE - 1;
    localparam int unsigned COL_MASK  = PATCH_SIZE - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    logic [PIXEL_WIDTH-1:0] r_buf [BAND_PIX];

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_wr_cnt;
    logic [AW-1:0]          r_rd_ptr;
    logic [BW-1:0]          r_band;
    logic [AW-1:0]          w_wr_cnt_nxt;
    logic [AW-1:0]          w_rd_ptr_nxt;
    logic [BW-1:0]          w_band_nxt;
    logic                   w_wr_fire;
    logic [AW-1:0]          w_pos;
    logic [AW-1:0]          w_pc;
    logic [AW-1:0]          w_row;
    logic [AW-1:0]          w_col;
    logic [AW-1:0]          w_wr_addr;

    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_frame_done;
    logic [PIXEL_WIDTH-1:0] r_out_data;

    // Band-buffer write address from the patch-major input count
    always_comb begin
        w_pos     = r_wr_cnt & AW'(POS_MASK);
        w_pc      = r_wr_cnt >> (2 * PATCH_SIZE_LOG2);
        w_row     = w_pos >> PATCH_SIZE_LOG2;
        w_col     = w_pos & AW'(COL_MASK);
        w_wr_addr = AW'(32'(w_row) * IMG_WIDTH) + AW'(w_pc << PATCH_SIZE_LOG2) + w_col;
    end

    // Next-state and next-counter logic
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_ptr_nxt = r_rd_ptr;
        w_band_nxt   = r_band;
        w_wr_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt  = S_FILL;
                    w_wr_cnt_nxt = '0;
                    w_rd_ptr_nxt = '0;
                    w_band_nxt   = '0;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    w_wr_fire = 1'b1;
                    if (r_wr_cnt == AW'(BAND_PIX - 1)) begin
                        w_wr_cnt_nxt = '0;
                        w_state_nxt  = S_DRAIN;
                    end else begin
                        w_wr_cnt_nxt = r_wr_cnt + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (r_rd_ptr == AW'(BAND_PIX - 1)) begin
                        w_rd_ptr_nxt = '0;
                        if (r_band == BW'(NUM_BANDS - 1)) begin
                            w_band_nxt  = '0;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_band_nxt  = r_band + BW'(1);
                            w_state_nxt = S_FILL;
                        end
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered handshake/data outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wr_cnt     <= '0;
            r_rd_ptr     <= '0;
            r_band       <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_cnt     <= w_wr_cnt_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_band       <= w_band_nxt;
            r_in_ready   <= (w_state_nxt == S_FILL);
            r_out_valid  <= (w_state_nxt == S_DRAIN);
            r_frame_done <= (w_state_nxt == S_DONE);
            r_out_data   <= r_buf[w_rd_ptr_nxt];
        end
    end

    // Band buffer storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_buf[w_wr_addr] <= in_data;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;
    assign state      = r_state;

`ifdef UNPATCHIFIER_MARKERS_EN
    logic r_out_eol;
    logic r_out_last;

    // Row-end and frame-end markers aligned with the registered output pixel
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_eol  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            r_out_eol  <= (w_state_nxt == S_DRAIN) &&
                          ((32'(w_rd_ptr_nxt) % IMG_WIDTH) == (IMG_WIDTH - 1));
            r_out_last <= (w_state_nxt == S_DRAIN) &&
                          (w_rd_ptr_nxt == AW'(BAND_PIX - 1)) &&
                          (w_band_nxt == BW'(NUM_BANDS - 1));
        end
    end

    assign out_eol  = r_out_eol;
    assign out_last = r_out_last;
`endif

endmodule

// File: tb/tb_unpatchifier.sv
// Testbench for unpatchifier: 8x8 image, 4x4 patches, randomized handshakes
// checked against an index-arithmetic reference of the patch-to-raster mapping.
module tb_unpatchifier;

    localparam int unsigned W   = 8;
    localparam int unsigned H   = 8;
    localparam int unsigned PS  = 4;
    localparam int unsigned PW  = 24;
    localparam int unsigned NPX = W * H;
    localparam int unsigned PPR = W / PS;
    localparam int          BUDGET = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    state;
    logic          frame_done;
`ifdef UNPATCHIFIER_MARKERS_EN
    logic          out_eol;
    logic          out_last;
`endif

    unpatchifier #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .PATCH_SIZE     (PS),
        .PATCH_SIZE_LOG2(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .state     (state),
        .frame_done(frame_done)
`ifdef UNPATCHIFIER_MARKERS_EN
        ,
        .out_eol   (out_eol),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [PW-1:0] in_seq  [NPX];
    logic [PW-1:0] exp_ras [NPX];

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Build input stream and expected raster image
    task automatic build_frame(input bit pattern);
        for (int p = 0; p < int'(NPX / (PS * PS)); p++) begin
            for (int pos = 0; pos < int'(PS * PS); pos++) begin
                int k;
                int row;
                int col;
                k   = p * PS * PS + pos;
                row = (p / PPR) * PS + pos / PS;
                col = (p % PPR) * PS + pos % PS;
                in_seq[k]            = pattern ? PW'(p * 16 + pos) : PW'($urandom);
                exp_ras[row * W + col] = in_seq[k];
            end
        end
    endtask

    // Pulse en (unless already held high) and confirm entry into FILL
    task automatic start_frame(input bit en_held);
        if (!en_held) en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("start_state", 32'(state), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Stream one frame with random stalls; optional abort, en pokes, back-to-back en
    task automatic stream(input int stall_pct, input int abort_after, input bit pattern,
                          input bit poke_en, input bit b2b);
        int in_idx = 0;
        int out_idx = 0;
        int done_cnt = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [PW-1:0] prev_data = '0;
        bit fin = 1'b0;
        while (cyc < BUDGET && !fin) begin
            if (frame_done) begin
                done_cnt++;
                check("done_after_last", 32'(out_idx), 32'(NPX));
            end
            if (prev_stall && out_valid) check("stall_hold", 32'(out_data), 32'(prev_data));
            if (abort_after > 0 && in_idx == abort_after) begin
                reset = 1'b0; in_valid = 1'b0; en = 1'b0;
                @(negedge clk);
                check("abort_state", 32'(state), 32'd0);
                check("abort_in_ready", 32'(in_ready), 32'd0);
                check("abort_out_valid", 32'(out_valid), 32'd0);
                reset = 1'b1;
                @(negedge clk);
                return;
            end
            if (done_cnt > 0 && state == 2'b00) begin
                fin = 1'b1;
            end else begin
                in_valid  = ($urandom_range(99) >= 32'(stall_pct));
                out_ready = ($urandom_range(99) >= 32'(stall_pct));
                en = (b2b && frame_done) ? 1'b1 :
                     (poke_en && (state == 2'b01 || state == 2'b10)) ? 1'($urandom_range(1)) : 1'b0;
                in_data = (state == 2'b01 && in_idx < int'(NPX)) ? in_seq[in_idx] : PW'($urandom);
                if (out_valid && out_ready) begin
                    if (out_idx < int'(NPX)) check("raster_px", 32'(out_data), 32'(exp_ras[out_idx]));
                    if (pattern && out_idx == 46) check("px_r5c6", 32'(out_data), 32'd54);
`ifdef UNPATCHIFIER_MARKERS_EN
                    check("eol", 32'(out_eol), 32'(out_idx % W == W - 1));
                    check("last", 32'(out_last), 32'(out_idx == int'(NPX) - 1));
`endif
                    out_idx++;
                end
                if (state == 2'b01 && in_valid && in_ready) in_idx++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        if (!(b2b && done_cnt > 0)) en = 1'b0;
        check("timeout", 32'(cyc >= BUDGET), 32'd0);
        check("frame_done_cnt", 32'(done_cnt), 32'd1);
        check("out_count", 32'(out_idx), 32'(NPX));
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_state", 32'(state), 32'd0);

        // Clean frame, then a back-to-back stalled repeat of it
        build_frame(1'b1);
        start_frame(1'b0);
        stream(0, 0, 1'b1, 1'b0, 1'b1);
        start_frame(1'b1);
        stream(30, 0, 1'b1, 1'b0, 1'b0);

        // Abandon a random frame mid-FILL, then the pattern frame again
        build_frame(1'b0);
        start_frame(1'b0);
        stream(30, 20, 1'b0, 1'b0, 1'b0);
        build_frame(1'b1);
        start_frame(1'b0);
        stream(0, 0, 1'b1, 1'b0, 1'b0);

        // Random data with en pokes during FILL/DRAIN and in_valid garbage in DRAIN
        build_frame(1'b0);
        start_frame(1'b0);
        stream(30, 0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
